// File: rtl/rc4_key_search_ctrl.sv
// Key-space dispatcher for the multi-core RC4 brute-force search: hands ascending
// candidate keys to NUM_CORES decrypt cores, stops on first success or exhaustion.
module rc4_key_search_ctrl #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_success,
    output logic                           core_abort,
    output logic                           busy,
    output logic [1:0]                     status,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH:0]             keys_tested
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(NUM_CORES + 1);
    localparam int TW    = KEY_WIDTH + 1;
    // One extra bit so that KEY_MAX = all-ones still terminates instead of wrapping.
    localparam logic [KEY_WIDTH:0] KEY_LIMIT = {1'b0, KEY_MAX};

    typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_CORES-1:0]   core_busy_reg, core_busy_next;
    logic [KEY_WIDTH:0]     next_key_reg, next_key_next;
    logic [KEY_WIDTH-1:0]   key_slot_reg [NUM_CORES];
    logic [KEY_WIDTH-1:0]   key_slot_next [NUM_CORES];
    logic [NUM_CORES-1:0]   core_start_reg, core_start_next;
    logic                   core_abort_reg, core_abort_next;
    logic                   busy_reg, busy_next;
    logic [1:0]             status_reg, status_next;
    logic [KEY_WIDTH-1:0]   found_key_reg, found_key_next;
    logic [KEY_WIDTH:0]     keys_tested_reg, keys_tested_next;

    logic [NUM_CORES-1:0]   done_valid, fail_vec, succ_vec;
    logic [CNT_W-1:0]       fail_count;
    logic [IDX_W-1:0]       succ_idx, free_idx;
    logic                   free_any;

    // Results from cores that are not marked busy are stale and dropped here.
    always_comb begin
        done_valid = core_done & core_busy_reg;
        fail_vec   = done_valid & ~core_success;
        succ_vec   = done_valid & core_success;
        fail_count = '0;
        succ_idx   = '0;
        free_idx   = '0;
        free_any   = 1'b0;
        // Scanning downward lets the lowest index overwrite and win.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            fail_count = fail_count + CNT_W'(fail_vec[i]);
            if (succ_vec[i]) begin
                succ_idx = IDX_W'(i);
            end
            if (!core_busy_reg[i]) begin
                free_idx = IDX_W'(i);
                free_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        core_busy_next   = core_busy_reg;
        next_key_next    = next_key_reg;
        key_slot_next    = key_slot_reg;
        core_start_next  = '0;
        core_abort_next  = 1'b0;
        status_next      = status_reg;
        found_key_next   = found_key_reg;
        keys_tested_next = keys_tested_reg;
        case (state_reg)
            RUN: begin
                core_busy_next   = core_busy_reg & ~done_valid;
                keys_tested_next = keys_tested_reg + TW'(fail_count);
                if (|succ_vec) begin
                    found_key_next  = key_slot_reg[succ_idx];
                    core_abort_next = 1'b1;
                    status_next     = 2'b01;
                    state_next      = FOUND;
                end else if (free_any && (next_key_reg <= KEY_LIMIT)) begin
                    // Free status comes from the registered busy bits, so a core
                    // finishing this cycle is only redispatched next cycle.
                    key_slot_next[free_idx]   = next_key_reg[KEY_WIDTH-1:0];
                    core_start_next[free_idx] = 1'b1;
                    core_busy_next[free_idx]  = 1'b1;
                    next_key_next             = next_key_reg + TW'(1);
                end else if ((next_key_reg > KEY_LIMIT) && (core_busy_next == '0)) begin
                    status_next = 2'b10;
                    state_next  = EXHAUSTED;
                end
            end
            default: begin
                if (start) begin
                    state_next       = RUN;
                    status_next      = 2'b00;
                    found_key_next   = '0;
                    keys_tested_next = '0;
                    next_key_next    = '0;
                    core_busy_next   = '0;
                end
            end
        endcase
        busy_next = (state_next == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            core_busy_reg   <= '0;
            next_key_reg    <= '0;
            core_start_reg  <= '0;
            core_abort_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            status_reg      <= 2'b00;
            found_key_reg   <= '0;
            keys_tested_reg <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                key_slot_reg[i] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            core_busy_reg   <= core_busy_next;
            next_key_reg    <= next_key_next;
            core_start_reg  <= core_start_next;
            core_abort_reg  <= core_abort_next;
            busy_reg        <= busy_next;
            status_reg      <= status_next;
            found_key_reg   <= found_key_next;
            keys_tested_reg <= keys_tested_next;
            for (int i = 0; i < NUM_CORES; i++) begin
                key_slot_reg[i] <= key_slot_next[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_key
            assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] = key_slot_reg[gi];
        end
    endgenerate

    assign core_start  = core_start_reg;
    assign core_abort  = core_abort_reg;
    assign busy        = busy_reg;
    assign status      = status_reg;
    assign found_key   = found_key_reg;
    assign keys_tested = keys_tested_reg;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl: behavioural decrypt-core models with
// random latency, checked against the expected key sequence and search outcome.
module tb_rc4_key_search_ctrl;

    localparam int             NC   = 4;
    localparam int             KW   = 24;
    localparam logic [KW-1:0]  KMAX = 24'd15;

    logic              clk;
    logic              reset;
    logic              start;
    logic [NC-1:0]     core_start;
    logic [NC*KW-1:0]  core_key;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_success;
    logic              core_abort;
    logic              busy;
    logic [1:0]        status;
    logic [KW-1:0]     found_key;
    logic [KW:0]       keys_tested;

    rc4_key_search_ctrl #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_start(core_start), .core_key(core_key),
        .core_done(core_done), .core_success(core_success),
        .core_abort(core_abort), .busy(busy), .status(status),
        .found_key(found_key), .keys_tested(keys_tested)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Core model state
    bit            model_en = 1'b1;
    int            pass_key = -1;
    int            lat_min  = 5;
    int            lat_max  = 5;
    bit            pend [NC];
    int            cnt  [NC];
    logic [KW-1:0] held [NC];
    logic [NC-1:0] man_done = '0;
    logic [NC-1:0] man_succ = '0;
    logic [KW-1:0] issued_q [$];
    int            starts_seen = 0;
    int            aborts_seen = 0;

    initial begin
        core_done    = '0;
        core_success = '0;
        for (int i = 0; i < NC; i++) begin
            pend[i] = 1'b0;
            cnt[i]  = 0;
            held[i] = '0;
        end
    end

    // Cores react on the falling edge so the DUT samples stable inputs.
    always @(negedge clk) begin
        core_done    = model_en ? '0 : man_done;
        core_success = model_en ? '0 : man_succ;
        if (reset) begin
            for (int i = 0; i < NC; i++) pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    issued_q.push_back(core_key[i*KW +: KW]);
                    starts_seen++;
                end
            end
            if (core_abort) aborts_seen++;
            if (model_en) begin
                for (int i = 0; i < NC; i++) begin
                    if (core_abort) pend[i] = 1'b0;
                    if (pend[i]) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            core_done[i]    = 1'b1;
                            core_success[i] = (held[i] == pass_key);
                            pend[i]         = 1'b0;
                        end
                    end
                    if (core_start[i]) begin
                        pend[i] = 1'b1;
                        held[i] = core_key[i*KW +: KW];
                        cnt[i]  = $urandom_range(lat_max, lat_min);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic manual_pulse(input logic [NC-1:0] d, input logic [NC-1:0] s);
        man_done = d;
        man_succ = s;
        step();
        man_done = '0;
        man_succ = '0;
        step();
    endtask

    // Issued keys must form the ascending run 0,1,2,... with no repeats.
    task automatic check_issued_prefix(input string name, input int exp_len);
        int bad = 0;
        checks++;
        for (int k = 0; k < issued_q.size(); k++)
            if (issued_q[k] !== KW'(k)) bad++;
        if (bad != 0 || (exp_len >= 0 && issued_q.size() != exp_len)) begin
            failures++;
            $display("FAIL %s: issued %0d keys with %0d out of order, required %0d ascending from 0",
                     name, issued_q.size(), bad, exp_len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        checks++;
        if ({core_start, core_abort, busy, status} !== '0 || core_key !== '0 ||
            found_key !== '0 || keys_tested !== '0) begin
            failures++;
            $display("FAIL reset_values: start=%b abort=%b busy=%b status=%b key=%h found=%h tested=%0d, required all zero",
                     core_start, core_abort, busy, status, core_key, found_key, keys_tested);
        end
        reset = 1'b0;
        repeat (4) step();
        checks++;
        if (starts_seen != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: starts=%0d busy=%b, required 0 and 0", starts_seen, busy);
        end
    endtask

    // Waits for the search to leave RUN; returns 0 if the cycle budget expires.
    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (busy !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b status=%b after 600 cycles, required search end", name, busy, status);
        end
    endtask

    task automatic test_found_fixed();
        bit ok;
        int starts_at_abort;
        model_en = 1'b1; lat_min = 5; lat_max = 5; pass_key = 11;
        issued_q.delete(); aborts_seen = 0;
        pulse_start();
        wait_done("found_fixed", ok);
        checks++;
        if (status !== 2'b01 || found_key !== 24'h00000B || core_abort !== 1'b1) begin
            failures++;
            $display("FAIL found_fixed: status=%b found=%h abort=%b, required 01 00000b 1",
                     status, found_key, core_abort);
        end
        starts_at_abort = starts_seen;
        step();
        checks++;
        if (core_abort !== 1'b0) begin
            failures++;
            $display("FAIL abort_single_cycle: abort=%b one cycle later, required 0", core_abort);
        end
        repeat (10) step();
        checks++;
        if (starts_seen != starts_at_abort || aborts_seen != 1) begin
            failures++;
            $display("FAIL quiet_after_found: extra starts=%0d aborts=%0d, required 0 and 1",
                     starts_seen - starts_at_abort, aborts_seen);
        end
        check_issued_prefix("found_fixed_order", -1);
        $display("found_fixed: found=%h status=%b issued=%0d", found_key, status, issued_q.size());
    endtask

    task automatic test_exhaust();
        bit ok;
        model_en = 1'b1; lat_min = 1; lat_max = 8; pass_key = -1;
        issued_q.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || core_start !== 4'b0000 || status !== 2'b00) begin
            failures++;
            $display("FAIL start_busy: busy=%b core_start=%b status=%b, required 1 0000 00",
                     busy, core_start, status);
        end
        step();
        checks++;
        if (core_start !== 4'b0001 || core_key[0 +: KW] !== '0) begin
            failures++;
            $display("FAIL first_dispatch: core_start=%b key0=%h, required 0001 000000",
                     core_start, core_key[0 +: KW]);
        end
        step();
        checks++;
        if (core_start !== 4'b0010 || core_key[KW +: KW] !== 24'd1) begin
            failures++;
            $display("FAIL second_dispatch: core_start=%b key1=%h, required 0010 000001",
                     core_start, core_key[KW +: KW]);
        end
        repeat (4) step();
        pulse_start();
        wait_done("exhaust", ok);
        checks++;
        if (status !== 2'b10 || keys_tested !== 25'd16 || busy !== 1'b0) begin
            failures++;
            $display("FAIL exhaust_state: status=%b tested=%0d busy=%b, required 10 16 0",
                     status, keys_tested, busy);
        end
        repeat (3) step();
        check_issued_prefix("exhaust_order", int'(KMAX) + 1);
        $display("exhaust: status=%b tested=%0d issued=%0d", status, keys_tested, issued_q.size());
    endtask

    task automatic test_simultaneous_success();
        model_en = 1'b0;
        pulse_start();
        repeat (6) step();
        manual_pulse(4'b0011, 4'b0000);
        repeat (4) step();
        manual_pulse(4'b1100, 4'b0000);
        repeat (4) step();
        checks++;
        if (core_key[KW +: KW] !== 24'd5 || core_key[3*KW +: KW] !== 24'd7) begin
            failures++;
            $display("FAIL simul_setup: key1=%0d key3=%0d, required 5 and 7",
                     core_key[KW +: KW], core_key[3*KW +: KW]);
        end
        manual_pulse(4'b1010, 4'b1010);
        checks++;
        if (found_key !== 24'd5 || status !== 2'b01 || core_abort !== 1'b1 ||
            busy !== 1'b0 || keys_tested !== 25'd4) begin
            failures++;
            $display("FAIL simul_success: found=%0d status=%b abort=%b busy=%b tested=%0d, required 5 01 1 0 4",
                     found_key, status, core_abort, busy, keys_tested);
        end
        step();
        $display("simultaneous: found=%0d status=%b", found_key, status);
    endtask

    task automatic test_reset_midsearch();
        model_en = 1'b1; lat_min = 5; lat_max = 5; pass_key = -1;
        pulse_start();
        repeat (7) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || core_start !== '0 || core_key !== '0 || status !== 2'b00 ||
            keys_tested !== '0 || core_abort !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b start=%b key=%h status=%b tested=%0d, required all zero",
                     busy, core_start, core_key, status, keys_tested);
        end
        step();
        reset = 1'b0;
        repeat (2) step();
        issued_q.delete();
        pulse_start();
        step();
        checks++;
        if (core_start !== 4'b0001 || core_key[0 +: KW] !== '0 || keys_tested !== '0) begin
            failures++;
            $display("FAIL restart_after_reset: core_start=%b key0=%h tested=%0d, required 0001 0 0",
                     core_start, core_key[0 +: KW], keys_tested);
        end
        $display("reset_midsearch: restart key0=%h", core_key[0 +: KW]);
    endtask

    // Random pass key and latencies; each round restarts from FOUND.
    task automatic test_random_found();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            model_en = 1'b1; lat_min = 1; lat_max = 9;
            pass_key = $urandom_range(int'(KMAX), 0);
            wait_done("random_found", ok);
            checks++;
            if (status !== 2'b01 || found_key !== KW'(pass_key)) begin
                failures++;
                $display("FAIL random_found: status=%b found=%0d, required 01 %0d",
                         status, found_key, pass_key);
            end
            $display("random_found round %0d: pass=%0d found=%0d", r, pass_key, found_key);
            repeat (3) step();
            issued_q.delete();
            pulse_start();
            checks++;
            if (status !== 2'b00 || busy !== 1'b1) begin
                failures++;
                $display("FAIL start_in_found: status=%b busy=%b, required 00 1", status, busy);
            end
            step();
            checks++;
            if (core_start !== 4'b0001 || core_key[0 +: KW] !== '0) begin
                failures++;
                $display("FAIL restart_key0: core_start=%b key0=%h, required 0001 0",
                         core_start, core_key[0 +: KW]);
            end
        end
        pass_key = -1;
        wait_done("random_tail", ok);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_found_fixed();
        test_exhaust();
        test_simultaneous_success();
        test_reset_midsearch();
        test_random_found();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Parametrised key-space dispatcher for the RC4 brute-force decryption datapath. It hands candidate keys to `NUM_CORES` independent decrypt/check cores and collects their pass/fail results. It stops every core on the first success and latches the winning key for the HEX display and the LED status logic. It replaces the single-core, fixed-24-bit search loop with a multi-channel, width-configurable search that can be restarted and reports progress.

## Interface
- `NUM_CORES`, default 4: number of decrypt cores served (1..16).
- `KEY_WIDTH`, default 24: candidate key width in bits.
- `KEY_MAX`, default 24'h3FFFFF: last key searched; the search covers 0..KEY_MAX inclusive.

Ports:
- `clk` in 1: system clock (CLOCK_50 at top level).
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin or restart a search.
- `core_start` out NUM_CORES: one-cycle pulse per core, issuing a new candidate.
- `core_key` out NUM_CORES*KEY_WIDTH: candidate for core i in bits [i*KEY_WIDTH +: KEY_WIDTH]. Held stable from `core_start[i]` until that core's `core_done[i]`.
- `core_done` in NUM_CORES: one-cycle pulse when core i finishes its candidate.
- `core_success` in NUM_CORES: qualified by `core_done[i]`; 1 means the plaintext check passed.
- `core_abort` out 1: one-cycle pulse telling all cores to stop.
- `busy` out 1: search in progress.
- `status` out 2: 2'b00 idle/running, 2'b01 key found, 2'b10 key space exhausted.
- `found_key` out KEY_WIDTH: winning key, valid when status==2'b01.
- `keys_tested` out KEY_WIDTH+1: count of failed candidates in the current search.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: dispatching candidates and collecting results.
  - FOUND: success latched.
  - EXHAUSTED: every key tested, none passed.
- IDLE/FOUND/EXHAUSTED + `start` → RUN. On entry: clear `status`, `found_key`, `keys_tested`; set `next_key`=0; clear all per-core busy bits.
- `start` in RUN is ignored.
- Dispatch in RUN: at most one core per cycle.
  - Pick the lowest-index core whose busy bit is clear, provided `next_key` <= KEY_MAX.
  - Load its `core_key` slot with `next_key`, pulse its `core_start`, set its busy bit, increment `next_key`.
- `next_key` is KEY_WIDTH+1 bits wide, so KEY_MAX = 2^KEY_WIDTH-1 terminates without wrap-around.
- Completion: `core_done[i]` with busy bit i set clears busy bit i.
  - `core_success[i]`=0: `keys_tested`+1. Several failing cores in the same cycle add their total count.
  - `core_success[i]`=1: latch `found_key` from core i's slot, pulse `core_abort`, set `status`=2'b01, go to FOUND.
  - Simultaneous successes: the lowest-index core wins.
  - `core_done[i]` while busy bit i is clear is ignored.
- A core that completes in cycle t is not redispatched in cycle t. It is eligible from t+1.
- Exhaustion: `next_key` > KEY_MAX, all busy bits clear, and no success → `status`=2'b10, go to EXHAUSTED.
- In FOUND/EXHAUSTED all `core_done` inputs are ignored and `core_start` stays 0.
- Each key in 0..KEY_MAX is issued at most once per search, in ascending order.

## Timing
- All outputs are registered.
- Reset values: `core_start`=0, `core_key`=0, `core_abort`=0, `busy`=0, `status`=2'b00, `found_key`=0, `keys_tested`=0. State is IDLE.
- `start` sampled high at edge t: `busy`=1 after t. `core_start[0]`=1 with key 0 after edge t+1. Core k gets key k after edge t+1+k, assuming all cores are idle.
- Success on `core_done` sampled at edge t: after edge t, `status`=2'b01, `found_key` valid, `core_abort`=1 for exactly one cycle, `busy`=0.
- Exhaustion: the final failing `core_done` at edge t gives `status`=2'b10 and `busy`=0 after edge t.
- `reset` asserted mid-search: all outputs return to reset values immediately, without waiting for a clock edge. Pending core results are discarded.

## Test plan
- Reset with `reset`=1 for 3 cycles → every output at its reset value; `core_start` stays 0 without `start`.
- NUM_CORES=4, KEY_MAX=15, model cores with 5-cycle latency that pass only key 0x00000B → `found_key`=0x00000B, `status`=01. `core_abort` is a single-cycle pulse. No `core_start` pulse follows.
- Same setup with no passing key → keys 0..15 each issued exactly once, ascending. End state: `status`=10, `keys_tested`=16, `busy`=0.
- Cores 1 and 3 pulse `core_done`+`core_success` in the same cycle (keys 5 and 7) → `found_key`=5.
- Assert `reset` while 4 cores are busy, release it, then pulse `start` → the first `core_start[0]` carries key 0 and `keys_tested` is 0.
- Pulse `start` during RUN → no effect. Pulse `start` in FOUND → status clears to 00 and the search restarts at key 0.
